// File: rtl/operand_mux_pkg.sv
// Shared definitions for the pipelined operand select: default datapath
// width, the forwarding-unit select encodings and a select range helper.
package operand_mux_pkg;

    localparam int XLEN = 32;

    // Operand sources as driven by the forwarding unit.
    typedef enum logic [1:0] {
        SEL_REG     = 2'd0,
        SEL_FWD_MEM = 2'd1,
        SEL_FWD_WB  = 2'd2
    } operand_sel_e;

    // True when a select value addresses one of the n real inputs.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/operand_skid_buf.sv
// Two-entry valid/ready buffer: an output register backed by one skid
// register, so the upstream side can be fed from a registered ready.
//
// Handshake: a beat moves on a side only in a cycle where both valid and
// ready are high at the rising edge; valid never depends on ready, and a
// presented beat stays stable until it moves. in_ready is a flop equal to
// "skid register empty", which lets the input side stay fully registered.
module operand_skid_buf #(
    parameter int PW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_payload_q, out_payload_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_payload_q, skid_payload_d;
    logic          in_ready_q, in_ready_d;

    logic accept;
    logic deliver;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid_q & out_ready;

    // Next-state: refill the output register from skid first, else from the
    // input; park an input beat in skid only while the output is stalled.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_payload_d = skid_payload_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (deliver || !out_valid_q) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no input beat competes.
                out_valid_d   = 1'b1;
                out_payload_d = skid_payload_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_payload_d = in_payload;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_payload_d = in_payload;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset drops every held beat at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_payload_q  <= '0;
            skid_valid_q   <= 1'b0;
            skid_payload_q <= '0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_payload_q  <= out_payload_d;
            skid_valid_q   <= skid_valid_d;
            skid_payload_q <= skid_payload_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;

endmodule

// File: rtl/operand_mux_pipe.sv
// N:1 operand select with a registered, stallable output.
// Optional feature macro: OPERAND_MUX_SEL_CHK_EN adds sel_err (per-beat
// out-of-range flag) and err_cnt (saturating count of such accepts).
module operand_mux_pipe
    import operand_mux_pkg::*;
#(
    parameter int                WIDTH       = XLEN,
    parameter int                NUM_IN      = 3,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    localparam int               SEL_W       = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef OPERAND_MUX_SEL_CHK_EN
    ,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
`endif
);

`ifdef OPERAND_MUX_SEL_CHK_EN
    localparam int ERR_W = 1;
`else
    localparam int ERR_W = 0;
`endif
    localparam int PW = WIDTH + ERR_W;

    logic [WIDTH-1:0] sel_val;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;

    // Input-side select; anything past the last input yields DEFAULT_VAL.
    always_comb begin
        sel_val = DEFAULT_VAL;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(in_sel) == i) begin
                sel_val = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef OPERAND_MUX_SEL_CHK_EN
    logic       sel_oor;
    logic       accept;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign sel_oor    = !sel_in_range(32'(in_sel), NUM_IN);
    assign accept     = in_valid & in_ready;
    assign in_payload = {sel_oor, sel_val};

    // Count accepted out-of-range selects, holding at the top value.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && sel_oor && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sel_err = out_payload[WIDTH];
    assign err_cnt = err_cnt_q;
`else
    assign in_payload = sel_val;
`endif

    operand_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    assign out_data = out_payload[WIDTH-1:0];

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: directed scenarios then random traffic, all
// checked against a two-deep in-order queue model of the datapath.
module tb_operand_mux_pipe;
    import operand_mux_pkg::*;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int DW     = NUM_IN * WIDTH;
    localparam logic [WIDTH-1:0] DEF_VAL = '0;
    localparam logic [DW-1:0]    WORDS   = {32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5};

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef OPERAND_MUX_SEL_CHK_EN
    logic             sel_err;
    logic [7:0]       err_cnt;
`endif

    always #5 clk = ~clk;

    operand_mux_pipe #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .DEFAULT_VAL (DEF_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef OPERAND_MUX_SEL_CHK_EN
        ,
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_err_q[$];
    int               err_model = 0;
    int               n_checks  = 0;
    int               n_pass    = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference select: unpack the bus into words, pick one or the default.
    function automatic logic [WIDTH-1:0] ref_select(input logic [SEL_W-1:0] s, input logic [DW-1:0] d);
        logic [WIDTH-1:0] w[NUM_IN];
        for (int i = 0; i < NUM_IN; i++) w[i] = d[i*WIDTH +: WIDTH];
        if (int'(s) < NUM_IN) return w[s];
        return DEF_VAL;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(exp_q.size() > 0));
        check({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            check({tag, ".out_data"}, out_data, exp_q[0]);
`ifdef OPERAND_MUX_SEL_CHK_EN
            check({tag, ".sel_err"}, WIDTH'(sel_err), WIDTH'(exp_err_q[0]));
`endif
        end
`ifdef OPERAND_MUX_SEL_CHK_EN
        check({tag, ".err_cnt"}, WIDTH'(err_cnt), WIDTH'(err_model));
`endif
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input string tag);
        bit acc;
        bit del;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        acc = v && (exp_q.size() < 2);
        del = ordy && (exp_q.size() > 0);
        if (acc && (int'(s) >= NUM_IN) && (err_model < 255)) err_model++;
        if (fl) begin
            exp_q.delete();
            exp_err_q.delete();
        end else begin
            if (del) begin
                void'(exp_q.pop_front());
                void'(exp_err_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(ref_select(s, d));
                exp_err_q.push_back(int'(s) >= NUM_IN);
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        exp_err_q.delete();
        err_model = 0;
        check({tag, ".rst_out_valid"}, WIDTH'(out_valid), '0);
        check({tag, ".rst_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
        check({tag, ".rst_out_data"}, out_data, '0);
`ifdef OPERAND_MUX_SEL_CHK_EN
        check({tag, ".rst_sel_err"}, WIDTH'(sel_err), '0);
        check({tag, ".rst_err_cnt"}, WIDTH'(err_cnt), '0);
`endif
        #2 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset.out_valid", WIDTH'(out_valid), '0);
        check("reset.in_ready", WIDTH'(in_ready), WIDTH'(1));
        check("reset.out_data", out_data, '0);
`ifdef OPERAND_MUX_SEL_CHK_EN
        check("reset.sel_err", WIDTH'(sel_err), '0);
        check("reset.err_cnt", WIDTH'(err_cnt), '0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back selects with the output always ready.
        step(1'b1, SEL_REG,     WORDS, 1'b1, 1'b0, "t1.s0");
        check("t1.word0", out_data, 32'hA5A5A5A5);
        step(1'b1, SEL_FWD_MEM, WORDS, 1'b1, 1'b0, "t1.s1");
        check("t1.word1", out_data, 32'h12345678);
        step(1'b1, SEL_FWD_WB,  WORDS, 1'b1, 1'b0, "t1.s2");
        check("t1.word2", out_data, 32'hDEADBEEF);
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t1.drain");

        // Out-of-range select returns the default.
        step(1'b1, 2'd3, WORDS, 1'b1, 1'b0, "t2.oor");
        check("t2.default", out_data, 32'h0);
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t2.drain");

        // Stall for four cycles while two beats arrive, then release.
        step(1'b1, 2'd1, WORDS, 1'b0, 1'b0, "t3.a1");
        step(1'b1, 2'd2, WORDS, 1'b0, 1'b0, "t3.a2");
        check("t3.ready_low", WIDTH'(in_ready), '0);
        step(1'b1, 2'd0, WORDS, 1'b0, 1'b0, "t3.hold1");
        step(1'b0, 2'd0, WORDS, 1'b0, 1'b0, "t3.hold2");
        check("t3.hold_data", out_data, 32'h12345678);
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t3.rel1");
        check("t3.second", out_data, 32'hDEADBEEF);
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t3.rel2");

        // Flush with both entries held and input offered.
        step(1'b1, 2'd0, WORDS, 1'b0, 1'b0, "t4.f1");
        step(1'b1, 2'd1, WORDS, 1'b0, 1'b0, "t4.f2");
        step(1'b1, 2'd2, WORDS, 1'b0, 1'b1, "t4.flush_full");
        // Flush with one entry held and an input accepted in the same cycle.
        step(1'b1, 2'd0, WORDS, 1'b0, 1'b0, "t4.g1");
        step(1'b1, 2'd2, WORDS, 1'b1, 1'b1, "t4.flush_acc");
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t4.after");

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 2'd1, WORDS, 1'b0, 1'b0, "t5.a1");
        step(1'b1, 2'd2, WORDS, 1'b0, 1'b0, "t5.a2");
        async_reset_pulse("t5");
        step(1'b1, 2'd2, WORDS, 1'b1, 1'b0, "t5.post1");
        step(1'b1, 2'd0, WORDS, 1'b1, 1'b0, "t5.post2");
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "t5.drain");

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            logic          v, ordy, fl;
            logic [DW-1:0] d;
            fl   = ($urandom_range(0, 24) == 0);
            v    = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = {$urandom, $urandom, $urandom};
            step(v, SEL_W'($urandom_range(0, 3)), d, ordy, fl, "rnd");
        end
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "rnd.drain1");
        step(1'b0, '0, WORDS, 1'b1, 1'b0, "rnd.drain2");

`ifdef OPERAND_MUX_SEL_CHK_EN
        // Error counter saturation, survives flush, cleared by reset.
        async_reset_pulse("t6.pre");
        for (int n = 0; n < 300; n++) begin
            step(1'b1, 2'd3, {$urandom, $urandom, $urandom}, 1'b1, 1'b0, "t6.oor");
        end
        check("t6.saturated", WIDTH'(err_cnt), WIDTH'(255));
        step(1'b0, '0, WORDS, 1'b1, 1'b1, "t6.flush");
        check("t6.after_flush", WIDTH'(err_cnt), WIDTH'(255));
        async_reset_pulse("t6.rst");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
